// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - cycle-based grant FSM sharing one memory port between instruction fetch and data access
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_inst,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_func3,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_func3,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [31:0]       mem_rdata
);
    localparam int              SC_W       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    // Wait counter counts down from READ_LAT-1; zero marks the cycle mem_rdata is valid.
    localparam logic [1:0]      WAIT_INIT  = 2'(READ_LAT - 1);
    localparam logic [2:0]      FUNC3_LW   = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_I,
        WAIT_I,
        ISSUE_D,
        WAIT_D,
        WRITE_D
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      wait_cnt, wait_nxt;
    logic [SC_W-1:0] starve_cnt, starve_nxt;
    logic            grant_i, grant_d;
    logic            capture_i, capture_d, commit_d;

    // Stalls are the raw "request outstanding and not completing this cycle" view for the hazard unit.
    assign if_stall = if_req && !if_valid;
    assign d_stall  = d_req && !d_valid;

    // State register: FSM state, read-latency countdown and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Next-state and grant decision; no grant is made while a valid pulses so the requester can advance.
    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        starve_nxt = starve_cnt;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        capture_i  = 1'b0;
        capture_d  = 1'b0;
        commit_d   = 1'b0;
        case (state)
            IDLE: begin
                if (!if_valid && !d_valid) begin
                    if (d_req && ((starve_cnt < STARVE_LIM) || !if_req)) begin
                        grant_d   = 1'b1;
                        state_nxt = d_we ? WRITE_D : ISSUE_D;
                        if (!if_req) begin
                            starve_nxt = '0;
                        end else if (starve_cnt != STARVE_LIM) begin
                            starve_nxt = starve_cnt + SC_W'(1);
                        end
                    end else if (if_req) begin
                        grant_i    = 1'b1;
                        state_nxt  = ISSUE_I;
                        starve_nxt = '0;
                    end else begin
                        starve_nxt = '0;
                    end
                end
            end
            ISSUE_I: begin
                state_nxt = WAIT_I;
                wait_nxt  = WAIT_INIT;
            end
            WAIT_I: begin
                if (wait_cnt == 2'd0) begin
                    capture_i = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_nxt = wait_cnt - 2'd1;
                end
            end
            ISSUE_D: begin
                state_nxt = WAIT_D;
                wait_nxt  = WAIT_INIT;
            end
            WAIT_D: begin
                if (wait_cnt == 2'd0) begin
                    capture_d = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_nxt = wait_cnt - 2'd1;
                end
            end
            WRITE_D: begin
                commit_d  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side drive and result capture; address/data/func3 are registered at grant and held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_func3 <= '0;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
        end else begin
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            if_valid <= capture_i;
            d_valid  <= capture_d | commit_d;
            if (grant_i) begin
                mem_rd    <= 1'b1;
                mem_addr  <= if_addr;
                mem_func3 <= FUNC3_LW;
            end
            if (grant_d) begin
                mem_addr  <= d_addr;
                mem_func3 <= d_func3;
                if (d_we) begin
                    mem_wr    <= 1'b1;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_rd <= 1'b1;
                end
            end
            if (capture_i) begin
                if_inst <= mem_rdata;
            end
            if (capture_d) begin
                d_rdata <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table-driven bench for mem_port_arbiter across READ_LAT 1..4
module tb_mem_port_arbiter;
    localparam int AW = 14;
    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [31:0]   d_wdata;
    logic [2:0]    d_func3;
    logic [NI-1:0] sel;

    logic          if_req_a [NI];
    logic          d_req_a [NI];
    logic          if_valid_a [NI];
    logic          if_stall_a [NI];
    logic          d_valid_a [NI];
    logic          d_stall_a [NI];
    logic          mem_rd_a [NI];
    logic          mem_wr_a [NI];
    logic [31:0]   if_inst_a [NI];
    logic [31:0]   d_rdata_a [NI];
    logic [31:0]   mem_wdata_a [NI];
    logic [31:0]   mem_rdata_a [NI];
    logic [AW-1:0] mem_addr_a [NI];
    logic [2:0]    mem_func3_a [NI];

    logic [31:0]   mem_w [0:4095];
    logic [31:0]   pipe [NI][NI];

    int total, bad;

    typedef struct {
        logic        is_f;
        logic        we;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [13];

    genvar k;
    generate
        for (k = 0; k < NI; k++) begin : g
            assign if_req_a[k]    = if_req & sel[k];
            assign d_req_a[k]     = d_req & sel[k];
            assign mem_rdata_a[k] = pipe[k][k];
            mem_port_arbiter #(.ADDR_W(AW), .READ_LAT(k + 1), .STARVE_MAX(3)) u_dut (
                .clk(clk), .rst(rst),
                .if_req(if_req_a[k]), .if_addr(if_addr), .if_valid(if_valid_a[k]),
                .if_inst(if_inst_a[k]), .if_stall(if_stall_a[k]),
                .d_req(d_req_a[k]), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
                .d_func3(d_func3), .d_valid(d_valid_a[k]), .d_rdata(d_rdata_a[k]),
                .d_stall(d_stall_a[k]),
                .mem_addr(mem_addr_a[k]), .mem_wdata(mem_wdata_a[k]), .mem_func3(mem_func3_a[k]),
                .mem_rd(mem_rd_a[k]), .mem_wr(mem_wr_a[k]), .mem_rdata(mem_rdata_a[k])
            );
            a_d_proto: assert property (@(posedge clk) disable iff (rst) !($fell(d_req_a[k]) && !d_valid_a[k]))
                else $error("protocol: d_req dropped before d_valid on instance %0d", k);
            a_i_proto: assert property (@(posedge clk) disable iff (rst) !($fell(if_req_a[k]) && !if_valid_a[k]))
                else $error("protocol: if_req dropped before if_valid on instance %0d", k);
        end
    endgenerate

    function automatic logic [31:0] ld_fmt(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        case (f3)
            3'b000: r[{off, 3'b000} +: 8] = wd[7:0];
            3'b001: if (off[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // Memory array model: seeded on reset, byte-lane stores from whichever instance writes.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem_w[i] <= 32'h0;
            mem_w[1]  <= 32'h00500113;
            mem_w[4]  <= 32'h00A00093;
            mem_w[32] <= 32'h00000014;
            mem_w[33] <= 32'h8899AABB;
            mem_w[34] <= 32'h11223344;
        end else begin
            for (int j = 0; j < NI; j++) begin
                if (mem_wr_a[j]) begin
                    mem_w[mem_addr_a[j][AW-1:2]] <= st_merge(mem_w[mem_addr_a[j][AW-1:2]],
                        mem_addr_a[j][1:0], mem_func3_a[j], mem_wdata_a[j]);
                end
            end
        end
    end

    // Read pipeline per instance: data appears exactly READ_LAT cycles after mem_rd, garbage otherwise.
    always @(posedge clk) begin
        for (int j = 0; j < NI; j++) begin
            pipe[j][0] <= mem_rd_a[j] ? ld_fmt(mem_w[mem_addr_a[j][AW-1:2]], mem_addr_a[j][1:0], mem_func3_a[j])
                                      : 32'hBADC0DE0;
            for (int i = 1; i < NI; i++) pipe[j][i] <= pipe[j][i-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input int ki, input string tag);
        chk({tag, "_flags"}, {26'b0, if_valid_a[ki], d_valid_a[ki], mem_rd_a[ki], mem_wr_a[ki],
                              if_stall_a[ki], d_stall_a[ki]}, 32'h0);
        chk({tag, "_if_inst"}, if_inst_a[ki], 32'h0);
        chk({tag, "_d_rdata"}, d_rdata_a[ki], 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata_a[ki], 32'h0);
        chk({tag, "_mem_addr_f3"}, {15'b0, mem_addr_a[ki], mem_func3_a[ki]}, 32'h0);
    endtask

    task automatic run_vec(input int ki, input int vi, input vec_t v);
        int          vt, nrd, nwr, iss_c, nv_extra, stall_ok, excl_ok, exp_lat;
        logic [AW-1:0] iss_addr;
        logic [2:0]  iss_f3;
        logic [31:0] iss_wd, got;
        logic        vnow, onow, snow;
        string       tag;
        tag     = $sformatf("k%0d_v%0d", ki, vi);
        exp_lat = v.we ? 2 : 3 + ki;
        vt = -1; nrd = 0; nwr = 0; iss_c = -1; nv_extra = 0; stall_ok = 1; excl_ok = 1;
        iss_addr = '0; iss_f3 = '0; iss_wd = '0; got = '0;
        @(negedge clk);
        sel = '0;
        sel[ki] = 1'b1;
        if_addr = v.addr; d_addr = v.addr; d_we = v.we; d_wdata = v.wdata; d_func3 = v.f3;
        if (v.is_f) if_req = 1'b1; else d_req = 1'b1;
        #1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (mem_rd_a[ki]) begin nrd++; iss_c = c; iss_addr = mem_addr_a[ki]; iss_f3 = mem_func3_a[ki]; end
            if (mem_wr_a[ki]) begin
                nwr++; iss_c = c; iss_addr = mem_addr_a[ki]; iss_f3 = mem_func3_a[ki]; iss_wd = mem_wdata_a[ki];
            end
            if (mem_rd_a[ki] && mem_wr_a[ki]) excl_ok = 0;
            vnow = v.is_f ? if_valid_a[ki] : d_valid_a[ki];
            onow = v.is_f ? d_valid_a[ki] : if_valid_a[ki];
            snow = v.is_f ? if_stall_a[ki] : d_stall_a[ki];
            if (onow) excl_ok = 0;
            if (vt < 0) begin
                if (snow == vnow) stall_ok = 0;
                if (vnow) begin
                    vt = c;
                    got = v.is_f ? if_inst_a[ki] : d_rdata_a[ki];
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end else begin
                if (vnow) nv_extra++;
                if (snow) stall_ok = 0;
            end
            if (vt >= 0 && c >= vt + 3) break;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk({tag, "_latency"}, vt, exp_lat);
        chk({tag, "_issue_cycle"}, iss_c, 1);
        chk({tag, "_rd_pulses"}, nrd, v.we ? 0 : 1);
        chk({tag, "_wr_pulses"}, nwr, v.we ? 1 : 0);
        chk({tag, "_extra_valid"}, nv_extra, 0);
        chk({tag, "_mem_addr"}, {18'b0, iss_addr}, {18'b0, v.addr});
        chk({tag, "_mem_func3"}, {29'b0, iss_f3}, v.is_f ? 32'd2 : {29'b0, v.f3});
        chk({tag, "_stall"}, stall_ok, 1);
        chk({tag, "_exclusive"}, excl_ok, 1);
        if (v.we) begin
            chk({tag, "_mem_wdata"}, iss_wd, v.wdata);
        end else begin
            chk({tag, "_data"}, got, v.exp);
            chk({tag, "_data_hold"}, v.is_f ? if_inst_a[ki] : d_rdata_a[ki], v.exp);
        end
    endtask

    initial begin
        int          dv, iv, nrd, stall_ok, excl_ok, data_ok, nev, last_c, nv;
        int          rd_c [2];
        logic [AW-1:0] rd_a [2];
        logic [2:0]  rd_f [2];
        logic [31:0] dgot, igot;
        logic [8:0]  pat;

        total = 0; bad = 0;
        rst = 1'b1; sel = '0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_func3 = '0;

        //           is_f  we    addr      wdata         f3      expected
        tbl[0]  = '{1'b1, 1'b0, 14'h0010, 32'h0,        3'b010, 32'h00A00093};
        tbl[1]  = '{1'b0, 1'b0, 14'h0080, 32'h0,        3'b010, 32'h00000014};
        tbl[2]  = '{1'b0, 1'b1, 14'h0084, 32'h123456FF, 3'b000, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 14'h0084, 32'h0,        3'b100, 32'h000000FF};
        tbl[4]  = '{1'b0, 1'b0, 14'h0084, 32'h0,        3'b000, 32'hFFFFFFFF};
        tbl[5]  = '{1'b0, 1'b0, 14'h0086, 32'h0,        3'b001, 32'hFFFF8899};
        tbl[6]  = '{1'b0, 1'b1, 14'h0088, 32'hCAFEBEEF, 3'b001, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 14'h0088, 32'h0,        3'b101, 32'h0000BEEF};
        tbl[8]  = '{1'b0, 1'b0, 14'h0089, 32'h0,        3'b000, 32'hFFFFFFBE};
        tbl[9]  = '{1'b0, 1'b1, 14'h008C, 32'hDEADBEEF, 3'b010, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 14'h008C, 32'h0,        3'b010, 32'hDEADBEEF};
        tbl[11] = '{1'b0, 1'b0, 14'h0084, 32'h0,        3'b010, 32'h8899AAFF};
        tbl[12] = '{1'b0, 1'b0, 14'h0087, 32'h0,        3'b100, 32'h00000088};

        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk_zero(i, $sformatf("reset_k%0d", i));
        rst = 1'b0;

        for (int ki = 0; ki < NI; ki++) begin
            for (int vi = 0; vi < 13; vi++) run_vec(ki, vi, tbl[vi]);
        end

        // Simultaneous fetch and load on READ_LAT=1: data first, fetch after the data pulse.
        @(negedge clk);
        sel = '0; sel[0] = 1'b1;
        if_addr = 14'h0004; d_addr = 14'h0080; d_we = 1'b0; d_func3 = 3'b010;
        if_req = 1'b1; d_req = 1'b1;
        #1;
        dv = -1; iv = -1; nrd = 0; stall_ok = 1; excl_ok = 1; dgot = '0; igot = '0;
        rd_c[0] = -1; rd_c[1] = -1; rd_a[0] = '0; rd_a[1] = '0; rd_f[0] = '0; rd_f[1] = '0;
        for (int c = 0; c < 20 && iv < 0; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (mem_rd_a[0] && nrd < 2) begin rd_c[nrd] = c; rd_a[nrd] = mem_addr_a[0]; rd_f[nrd] = mem_func3_a[0]; nrd++; end
            if (mem_rd_a[0] && mem_wr_a[0]) excl_ok = 0;
            if (if_valid_a[0] && d_valid_a[0]) excl_ok = 0;
            if (!if_valid_a[0] && !if_stall_a[0]) stall_ok = 0;
            if (d_valid_a[0] && dv < 0) begin dv = c; dgot = d_rdata_a[0]; d_req = 1'b0; end
            if (if_valid_a[0]) begin iv = c; igot = if_inst_a[0]; if_req = 1'b0; end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("simul_d_valid_cycle", dv, 3);
        chk("simul_d_rdata", dgot, 32'h00000014);
        chk("simul_if_valid_cycle", iv, 7);
        chk("simul_if_inst", igot, 32'h00500113);
        chk("simul_rd0_cycle", rd_c[0], 1);
        chk("simul_rd0_addr", {18'b0, rd_a[0]}, 32'h0080);
        chk("simul_rd1_cycle", rd_c[1], 5);
        chk("simul_rd1_addr_f3", {15'b0, rd_a[1], rd_f[1]}, {15'b0, 14'h0004, 3'b010});
        chk("simul_if_stall", stall_ok, 1);
        chk("simul_exclusive", excl_ok, 1);

        // Starvation guard: both requesters held, expect D D D I D D D I then D once fetch drops.
        @(negedge clk);
        sel = '0; sel[0] = 1'b1;
        if_addr = 14'h0010; d_addr = 14'h0080; d_we = 1'b0; d_func3 = 3'b010;
        if_req = 1'b1; d_req = 1'b1;
        #1;
        nev = 0; pat = '0; last_c = -1; excl_ok = 1; data_ok = 1;
        for (int c = 0; c < 60 && nev < 9; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (if_valid_a[0] && d_valid_a[0]) excl_ok = 0;
            if (mem_rd_a[0] && mem_wr_a[0]) excl_ok = 0;
            if (d_valid_a[0]) begin
                pat = {pat[7:0], 1'b0}; nev++; last_c = c;
                if (d_rdata_a[0] !== 32'h00000014) data_ok = 0;
                if (nev >= 9) d_req = 1'b0;
            end
            if (if_valid_a[0]) begin
                pat = {pat[7:0], 1'b1}; nev++; last_c = c;
                if (if_inst_a[0] !== 32'h00A00093) data_ok = 0;
                if (nev >= 8) if_req = 1'b0;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("starve_events", nev, 9);
        chk("starve_pattern", {23'b0, pat}, 32'h022);
        chk("starve_last_cycle", last_c, 35);
        chk("starve_data", data_ok, 1);
        chk("starve_exclusive", excl_ok, 1);

        // Reset during WAIT_D on the READ_LAT=3 instance: no valid afterwards, late data ignored.
        repeat (2) @(negedge clk);
        sel = '0; sel[2] = 1'b1;
        d_addr = 14'h0080; d_we = 1'b0; d_func3 = 3'b010; d_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rstmid_pending", {30'b0, d_stall_a[2], d_valid_a[2]}, 32'h2);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        #1;
        chk_zero(2, "rstmid");
        rst = 1'b0;
        nv = 0; data_ok = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (d_valid_a[2]) nv++;
            if (d_rdata_a[2] !== 32'h0) data_ok = 0;
        end
        chk("rstmid_no_valid", nv, 0);
        chk("rstmid_rdata_zero", data_ok, 1);
        run_vec(2, 100, tbl[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single-ported unified instruction/data memory between two requesters: the IF stage (instruction fetch) and the MEM stage (loads/stores).
- Replaces the clock-phase split (fetch on high phase, data on low phase) with a cycle-based grant FSM.
- Generates per-requester stall signals for the pipeline hazard unit.
- Sits between the pipeline stage registers and the memory array; the memory address, func3, MemRead and MemWrite are driven only by this block.

Parameters:
ADDR_W, 14, byte-address width on both requester ports and the memory port
READ_LAT, 1, memory read latency in cycles from mem_rd issue to valid mem_rdata (range 1..4)
STARVE_MAX, 3, maximum consecutive data grants while if_req is pending before fetch is forced

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high with if_addr stable until if_valid
if_addr  in  ADDR_W  fetch byte address (word-aligned)
if_valid  out  1  one-cycle pulse: if_inst is valid
if_inst  out  32  fetched instruction; holds its value between pulses
if_stall  out  1  if_req && !if_valid (combinational)
d_req  in  1  data request; held stable with all d_* inputs until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data
d_func3  in  3  access size/sign (LW/LH/LB/LBU/LHU, SW/SH/SB encodings)
d_valid  out  1  one-cycle pulse: load data is valid or store is committed
d_rdata  out  32  load result; holds its value between pulses
d_stall  out  1  d_req && !d_valid (combinational)
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  32  store data to memory
mem_func3  out  3  func3 to memory
mem_rd  out  1  MemRead to memory; one-cycle pulse per read
mem_wr  out  1  MemWrite to memory; one-cycle pulse per store
mem_rdata  in  32  memory read data; valid READ_LAT cycles after mem_rd

Behaviour:
- Reset: FSM goes to IDLE; the starve counter clears.
  - All outputs go to 0: if_inst, d_rdata, valids, mem_* and stalls.
  - An in-flight access is abandoned. No valid pulse follows, and late mem_rdata is ignored.
- FSM states: IDLE, ISSUE_I, WAIT_I, ISSUE_D, WAIT_D, WRITE_D.
- IDLE grant decision, made each cycle:
  - d_req && (starve_cnt < STARVE_MAX || !if_req): go to ISSUE_D if !d_we, or WRITE_D if d_we.
  - Otherwise, if if_req: go to ISSUE_I.
  - Otherwise: stay in IDLE.
- ISSUE_I and ISSUE_D:
  - Drive mem_rd=1 for one cycle. Drive mem_addr from if_addr or d_addr.
  - mem_func3 = 3'b010 for a fetch, or d_func3 for a load.
  - Then enter the WAIT state, which counts READ_LAT cycles.
- WAIT_x: on the final wait cycle, register mem_rdata into if_inst or d_rdata. Pulse the matching valid the next cycle and return to IDLE.
- Read latency: the request is seen in IDLE at cycle T.
  - mem_rd is high at T+1.
  - The valid pulse occurs at T+2+READ_LAT.
  - With READ_LAT=1, a load completes 3 cycles after it is first seen.
- WRITE_D:
  - Drive mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata and mem_func3=d_func3 for exactly one cycle.
  - d_valid pulses the following cycle, then the FSM returns to IDLE.
- Idle drive: when not issuing, mem_rd and mem_wr are 0. mem_addr, mem_wdata and mem_func3 hold their last values.
- Starve counter:
  - Increments on each data grant made while if_req is high, saturating at STARVE_MAX.
  - Clears on any fetch grant, and whenever if_req is low at a grant decision.
- Back-to-back requests: the request whose valid pulses is not re-granted in that same cycle. The earliest re-grant is the cycle after the pulse, which lets the requester drop or advance its request.
- Request protocol: a requester deasserting its req before valid is a protocol violation; behaviour is undefined and the bench flags it with an assertion.
- Width rules: addresses pass through unmodified. Byte lane selection and sign extension are done by the memory according to func3. The block never alters data.
- Exclusivity: at most one of mem_rd and mem_wr is high in any cycle. if_valid and d_valid are never high in the same cycle.

Test Plan:
- Fetch alone: rst released, if_req=1, if_addr=0x0010, memory word 0x00A00093 -> mem_rd pulse at T+1 with mem_addr=0x0010, mem_func3=3'b010; if_valid at T+3 with if_inst=0x00A00093; if_stall high during T..T+2.
- Simultaneous requests: if_req=1 (addr 0x0004) and d_req=1 load LW at addr 0x0080 -> data granted first, d_rdata=0x00000014 at T+3; fetch issued afterwards, if_valid at T+7; if_stall high throughout.
- Store then load: SB d_wdata=0x123456FF at 0x0084, then LBU at 0x0084 -> mem_wr one cycle with mem_func3=3'b000, d_valid the next cycle; the load returns 0x000000FF.
- Starvation guard, STARVE_MAX=3: d_req continuously high with loads while if_req is held -> exactly 3 data grants, then 1 fetch grant, then the counter clears; no cycle has both valids high.
- Reset mid-read: assert rst while in WAIT_D with READ_LAT=3 -> the next cycle all outputs are 0 and the FSM is in IDLE; no d_valid pulse follows even though mem_rdata later returns data.
- Latency sweep: READ_LAT=1,2,4 with a single load -> d_valid at T+3, T+4, T+6 respectively; mem_rd high for exactly one cycle in each case.
